// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: reaction-timer sequencer that arms a random delay, lights the LED,
// times the player's press in ms ticks, and tracks the best time, fouls and timeouts.
module reaction_game_ctrl #(
   parameter int DELAY_W   = 12,
   parameter int TIME_W    = 14,
   parameter int MIN_DELAY = 500,
   parameter int MAX_TIME  = 9999
) (
   input  logic               clock1,
   input  logic               resetn,
   input  logic               start_key,
   input  logic               react_key,
   input  logic [DELAY_W-1:0] rand_val,
   input  logic               tick_ms,
   input  logic               delay_done,
   output logic               delay_load,
   output logic [DELAY_W-1:0] delay_value,
   output logic               led,
   output logic [TIME_W-1:0]  react_time,
   output logic [TIME_W-1:0]  best_time,
   output logic               result_valid,
   output logic               foul,
   output logic               timeout
);
   localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, WAIT = 3'd2, LIT = 3'd3, DONE = 3'd4, FOUL = 3'd5;
   localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);

   logic [2:0]         start_sync_q, react_sync_q;
   logic               start_p_q, react_p_q;
   logic [2:0]         state_q, state_d;
   logic               first_q, first_d, load_q, load_d, led_q, led_d;
   logic               valid_q, valid_d, foul_q, foul_d, to_q, to_d;
   logic [DELAY_W-1:0] value_q, value_d;
   logic [TIME_W-1:0]  rt_q, rt_d, best_q, best_d, rt_inc;
   logic [DELAY_W:0]   delay_sum;

   assign delay_sum = {1'b0, rand_val} + (DELAY_W+1)'(MIN_DELAY);
   assign rt_inc    = rt_q + TIME_W'(1);

   // first_q masks delay_done for the cycle the external counter needs to reload
   always_comb begin
      state_d = state_q;
      first_d = 1'b0;
      load_d  = 1'b0;
      value_d = value_q;
      led_d   = led_q;
      rt_d    = rt_q;
      best_d  = best_q;
      valid_d = valid_q;
      foul_d  = foul_q;
      to_d    = to_q;
      case (state_q)
         ARM: begin
            state_d = WAIT;
            first_d = 1'b1;
         end
         WAIT:
            if (react_p_q) begin
               state_d = FOUL;
               foul_d  = 1'b1;
               valid_d = 1'b1;
               rt_d    = '0;
            end else if (delay_done && !first_q) begin
               state_d = LIT;
               led_d   = 1'b1;
            end
         LIT:
            if (react_p_q) begin
               state_d = DONE;
               led_d   = 1'b0;
               valid_d = 1'b1;
               best_d  = (rt_q < best_q) ? rt_q : best_q;
            end else if (tick_ms) begin
               rt_d = rt_inc;
               if (rt_inc == MAX_T) begin
                  state_d = DONE;
                  led_d   = 1'b0;
                  valid_d = 1'b1;
                  to_d    = 1'b1;
               end
            end
         default:
            if (start_p_q) begin
               state_d = ARM;
               load_d  = 1'b1;
               value_d = delay_sum[DELAY_W] ? '1 : delay_sum[DELAY_W-1:0];
               rt_d    = '0;
               valid_d = 1'b0;
               foul_d  = 1'b0;
               to_d    = 1'b0;
            end
      endcase
   end

   always_ff @(posedge clock1 or negedge resetn) begin
      if (!resetn) begin
         start_sync_q <= '0;
         react_sync_q <= '0;
         start_p_q    <= 1'b0;
         react_p_q    <= 1'b0;
         state_q      <= IDLE;
         first_q      <= 1'b0;
         load_q       <= 1'b0;
         value_q      <= '0;
         led_q        <= 1'b0;
         rt_q         <= '0;
         best_q       <= '1;
         valid_q      <= 1'b0;
         foul_q       <= 1'b0;
         to_q         <= 1'b0;
      end else begin
         start_sync_q <= {start_sync_q[1:0], start_key};
         react_sync_q <= {react_sync_q[1:0], react_key};
         start_p_q    <= start_sync_q[1] & ~start_sync_q[2];
         react_p_q    <= react_sync_q[1] & ~react_sync_q[2];
         state_q      <= state_d;
         first_q      <= first_d;
         load_q       <= load_d;
         value_q      <= value_d;
         led_q        <= led_d;
         rt_q         <= rt_d;
         best_q       <= best_d;
         valid_q      <= valid_d;
         foul_q       <= foul_d;
         to_q         <= to_d;
      end
   end

   assign delay_load   = load_q;
   assign delay_value  = value_q;
   assign led          = led_q;
   assign react_time   = rt_q;
   assign best_time    = best_q;
   assign result_valid = valid_q;
   assign foul         = foul_q;
   assign timeout      = to_q;
endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Top-level sequencer for the reaction timer game.
- On a start press it loads a random delay into the external delay counter and waits for that counter to finish. It then lights the stimulus LED and measures the player's reaction time in 1 ms ticks.
- Reports the result, keeps a best-time register, and flags early presses (fouls) and timeouts.
- Sits between the debounced push-buttons, the random source, the delay counter and the display/LED drivers.

Parameters:
- DELAY_W, 12, width of the random delay value and the delay counter load.
- TIME_W, 14, width of the reaction-time and best-time registers.
- MIN_DELAY, 500, offset added to the random value so the delay is never trivially short.
- MAX_TIME, 9999, reaction-time ceiling in ticks; reaching it ends the round as a timeout.

Ports:
- clock1  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start_key  in  1  start button, active-high level, asynchronous to clock1.
- react_key  in  1  reaction button, active-high level, asynchronous to clock1.
- rand_val  in  DELAY_W  free-running random value; sampled only in ARM.
- tick_ms  in  1  one-cycle 1 ms enable pulse.
- delay_done  in  1  level from the delay counter: high when its count has reached zero.
- delay_load  out  1  one-cycle pulse that loads delay_value into the delay counter.
- delay_value  out  DELAY_W  delay to load.
- led  out  1  stimulus LED.
- react_time  out  TIME_W  last measured reaction time in ticks.
- best_time  out  TIME_W  smallest valid react_time since reset.
- result_valid  out  1  high while a completed result is held.
- foul  out  1  early press in the current round.
- timeout  out  1  MAX_TIME reached in the current round.

Behaviour:
- Input conditioning:
  - start_key and react_key each pass through a 2-flop synchronizer.
  - A rising-edge detector follows each synchronizer, giving start_p and react_p.
  - Press-to-pulse latency is 3 cycles.
- Reset (asynchronous, resetn=0):
  - State goes to IDLE.
  - delay_load=0, delay_value=0, led=0, react_time=0, result_valid=0, foul=0, timeout=0.
  - best_time = all-ones (2^TIME_W-1), meaning no best yet.
  - Synchronizer flops are cleared.
  - Reset mid-round aborts the round immediately. best_time is lost.
- IDLE:
  - Outputs hold their last result.
  - start_p -> ARM.
- ARM (1 cycle):
  - delay_value <= rand_val + MIN_DELAY, saturated to 2^DELAY_W-1.
  - delay_load = 1 for exactly this cycle.
  - Clear react_time, result_valid, foul and timeout.
  - -> WAIT.
- WAIT:
  - led=0.
  - delay_done is ignored during the first cycle after ARM, to allow the counter to reload.
  - react_p -> FOUL.
  - Otherwise delay_done=1 -> LIT.
  - If react_p and delay_done occur in the same cycle, FOUL wins.
- LIT:
  - led=1.
  - Each tick_ms increments react_time.
  - react_p -> DONE.
  - Reaching react_time==MAX_TIME -> DONE with timeout=1; react_time holds MAX_TIME.
  - If react_p and tick_ms occur in the same cycle, the increment is not applied.
- DONE:
  - led=0, result_valid=1.
  - On entry, if timeout=0 and react_time < best_time, then best_time <= react_time. Equal times do not update.
  - start_p -> ARM, which starts a new round.
- FOUL:
  - foul=1, result_valid=1, react_time=0, led=0. best_time is unchanged.
  - start_p -> ARM.
- Other rules:
  - start_p during WAIT or LIT is ignored.
  - react_p in IDLE, DONE or FOUL is ignored.
  - tick_ms is ignored outside LIT.
  - All outputs are registered.

Test Plan:
- Reset, then start press with rand_val=100 -> delay_load pulses once, delay_value=600, led=0; delay_done rises -> led=1 within 1 cycle.
- In LIT, deliver 250 tick_ms pulses, then press react -> react_time=250, result_valid=1, led=0, best_time=250.
- Second round with a reaction of 300 ticks -> react_time=300, best_time stays 250. Third round with 180 -> best_time=180.
- React press during WAIT -> foul=1, react_time=0, led never asserts, best_time unchanged; a subsequent start press clears foul.
- No react press in LIT -> at tick 9999 timeout=1, react_time=9999, best_time unchanged. Separately, rand_val=4000 -> delay_value saturates to 4095.
- Assert resetn=0 mid-LIT at react_time=50 -> all outputs clear asynchronously and best_time=16383. React press and delay_done in the same cycle -> FOUL.
